// File: rtl/fetch_sequencer.sv
// fetch_sequencer: F-stage program counter for the five-stage MIPS pipeline.
// Chooses the next fetch address (exception entry, eret return, stall hold,
// D-stage redirect, or PC+4), registers it, and tags the fetched word with
// delay-slot and fetch-address-error status for the F/D register.
//
// Handshake note: there is no valid/ready pair here. The hazard unit's
// stall freezes F; every other input is sampled on each rising edge, and
// f_kill/f_adel/f_valid/f_exc_code are same-cycle functions of the inputs
// and of f_pc.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        d_redirect,
    input  logic [31:0] d_target,
    input  logic        eret_d,
    input  logic [31:0] epc,
    input  logic        f_is_ctrl,
    output logic [31:0] f_pc,
    output logic        f_bd,
    output logic        f_valid,
    output logic        f_kill,
    output logic        f_adel,
    output logic [4:0]  f_exc_code,
    output logic [1:0]  state
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] EXC  = 2'd1;
    localparam logic [1:0] ERET = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic        req_take;
    logic        eret_take;
    logic [32:0] base_diff;
    logic [32:0] limit_diff;

    // CP0 may keep Req high while M drains, so it is ignored during EXC.
    assign req_take  = req & (state_q != EXC);
    assign eret_take = eret_d & ~stall & ~req_take;

    // Borrow-out of the subtraction tells us which side of the bound f_pc is.
    assign base_diff  = {1'b0, pc_q} - {1'b0, IM_BASE};
    assign limit_diff = {1'b0, IM_LIMIT} - {1'b0, pc_q};

    // State, PC and delay-slot registers; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
        end
    end

    // Next-PC selection in priority order: exception, eret, stall, redirect, PC+4.
    always_comb begin
        state_d = RUN;
        pc_d    = pc_q;
        bd_d    = bd_q;
        if (req_take) begin
            state_d = EXC;
            pc_d    = EXC_PC;
            bd_d    = 1'b0;
        end else if (eret_take) begin
            state_d = ERET;
            pc_d    = epc;
            bd_d    = 1'b0;
        end else if (stall) begin
            // EXC and ERET are one-cycle states, so only RUN is really held.
            state_d = RUN;
        end else if (d_redirect) begin
            pc_d = d_target;
            bd_d = 1'b0;
        end else begin
            pc_d = pc_q + 32'd4;
            bd_d = f_is_ctrl;
        end
    end

    // Combinational status for the word currently in F.
    always_comb begin
        f_pc       = pc_q;
        f_bd       = bd_q;
        state      = state_q;
        f_kill     = eret_take;
        f_adel     = (pc_q[1:0] != 2'b00) | base_diff[32] | limit_diff[32];
        f_valid    = ~f_adel;
        f_exc_code = f_adel ? 5'd4 : 5'd0;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed walk through the fetch sequencer behaviour,
// followed by randomized traffic, checked against a behavioural model.
// Three instances share stimulus: default bounds, a widened IM_LIMIT, and
// widened IM_LIMIT with IM_BASE=0.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req;
  logic        d_redirect;
  logic [31:0] d_target;
  logic        eret_d;
  logic [31:0] epc;
  logic        f_is_ctrl;

  logic [31:0] pc_o    [3];
  logic        bd_o    [3];
  logic        valid_o [3];
  logic        kill_o  [3];
  logic        adel_o  [3];
  logic [4:0]  code_o  [3];
  logic [1:0]  state_o [3];

  logic [31:0] base_m  [3] = '{32'h0000_3000, 32'h0000_3000, 32'h0000_0000};
  logic [31:0] limit_m [3] = '{32'h0000_6ffc, 32'hffff_fffc, 32'hffff_fffc};

  // behavioural model: PC, delay-slot flag, and what happened at the last edge
  logic [31:0] pc_m     [3];
  logic        bd_m     [3];
  logic        was_exc  [3];
  logic        was_eret [3];

  int n_cmp;
  int n_fail;

  fetch_sequencer dut0 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .d_redirect(d_redirect),
    .d_target(d_target), .eret_d(eret_d), .epc(epc), .f_is_ctrl(f_is_ctrl),
    .f_pc(pc_o[0]), .f_bd(bd_o[0]), .f_valid(valid_o[0]), .f_kill(kill_o[0]),
    .f_adel(adel_o[0]), .f_exc_code(code_o[0]), .state(state_o[0])
  );

  fetch_sequencer #(.IM_LIMIT(32'hffff_fffc)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .d_redirect(d_redirect),
    .d_target(d_target), .eret_d(eret_d), .epc(epc), .f_is_ctrl(f_is_ctrl),
    .f_pc(pc_o[1]), .f_bd(bd_o[1]), .f_valid(valid_o[1]), .f_kill(kill_o[1]),
    .f_adel(adel_o[1]), .f_exc_code(code_o[1]), .state(state_o[1])
  );

  fetch_sequencer #(.IM_LIMIT(32'hffff_fffc), .IM_BASE(32'h0)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .d_redirect(d_redirect),
    .d_target(d_target), .eret_d(eret_d), .epc(epc), .f_is_ctrl(f_is_ctrl),
    .f_pc(pc_o[2]), .f_bd(bd_o[2]), .f_valid(valid_o[2]), .f_kill(kill_o[2]),
    .f_adel(adel_o[2]), .f_exc_code(code_o[2]), .state(state_o[2])
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, inst, obs, expv);
    end
  endtask

  function automatic logic model_adel(input int i);
    return (pc_m[i] % 4 != 0) || (pc_m[i] < base_m[i]) || (pc_m[i] > limit_m[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pc_m[i]     = RESET_PC;
      bd_m[i]     = 1'b0;
      was_exc[i]  = 1'b0;
      was_eret[i] = 1'b0;
    end
  endtask

  // compare every output of every instance against the model
  task automatic check_all();
    logic [31:0] exp_state;
    logic        exp_adel;
    logic        exp_kill;
    for (int i = 0; i < 3; i++) begin
      exp_state = was_exc[i] ? 32'd1 : (was_eret[i] ? 32'd2 : 32'd0);
      exp_adel  = model_adel(i);
      exp_kill  = eret_d && !stall && !(req && !was_exc[i]);
      chk("f_pc", i, pc_o[i], pc_m[i]);
      chk("f_bd", i, {31'b0, bd_o[i]}, {31'b0, bd_m[i]});
      chk("state", i, {30'b0, state_o[i]}, exp_state);
      chk("f_adel", i, {31'b0, adel_o[i]}, {31'b0, exp_adel});
      chk("f_valid", i, {31'b0, valid_o[i]}, {31'b0, !exp_adel});
      chk("f_exc_code", i, {27'b0, code_o[i]}, exp_adel ? 32'd4 : 32'd0);
      chk("f_kill", i, {31'b0, kill_o[i]}, {31'b0, exp_kill});
    end
  endtask

  // one clock: check at the falling edge, advance the model across the rising edge
  task automatic do_cycle();
    logic req_eff;
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      req_eff = req && !was_exc[i];
      if (req_eff) begin
        pc_m[i] = EXC_PC; bd_m[i] = 1'b0; was_exc[i] = 1'b1; was_eret[i] = 1'b0;
      end else if (eret_d && !stall) begin
        pc_m[i] = epc; bd_m[i] = 1'b0; was_exc[i] = 1'b0; was_eret[i] = 1'b1;
      end else begin
        was_exc[i]  = 1'b0;
        was_eret[i] = 1'b0;
        if (stall) begin
          // hold
        end else if (d_redirect) begin
          pc_m[i] = d_target; bd_m[i] = 1'b0;
        end else begin
          pc_m[i] = pc_m[i] + 32'd4; bd_m[i] = f_is_ctrl;
        end
      end
    end
  endtask

  // asynchronous reset in mid-cycle, checked immediately, released after an edge
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pc", i, pc_o[i], RESET_PC);
      chk("rst_bd", i, {31'b0, bd_o[i]}, 32'd0);
      chk("rst_state", i, {30'b0, state_o[i]}, 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; req = 1'b0; d_redirect = 1'b0; d_target = 32'h0;
    eret_d = 1'b0; epc = 32'h0; f_is_ctrl = 1'b0;
  endtask

  // directed steps then randomized traffic
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_pc", 0, pc_o[0], 32'h0000_3000);
    chk("reset_valid", 0, {31'b0, valid_o[0]}, 32'd1);
    chk("reset_kill", 0, {31'b0, kill_o[0]}, 32'd0);
    chk("reset_adel", 0, {31'b0, adel_o[0]}, 32'd0);
    chk("reset_code", 0, {27'b0, code_o[0]}, 32'd0);
    reset = 1'b0;

    // sequential fetch, branch at 3004
    do_cycle();
    chk("seq_3004", 0, pc_o[0], 32'h0000_3004);
    f_is_ctrl = 1'b1;
    do_cycle();
    f_is_ctrl = 1'b0;
    chk("seq_3008", 0, pc_o[0], 32'h0000_3008);
    chk("slot_bd", 0, {31'b0, bd_o[0]}, 32'd1);

    // two-cycle stall holding 3008 and its delay-slot tag
    stall = 1'b1;
    do_cycle();
    do_cycle();
    chk("stall_pc", 0, pc_o[0], 32'h0000_3008);
    chk("stall_bd", 0, {31'b0, bd_o[0]}, 32'd1);
    stall = 1'b0;

    // redirect resolved while the delay slot sits in F
    d_redirect = 1'b1; d_target = 32'h0000_3100;
    do_cycle();
    d_redirect = 1'b0;
    chk("redir_pc", 0, pc_o[0], 32'h0000_3100);
    chk("redir_bd", 0, {31'b0, bd_o[0]}, 32'd0);
    do_cycle();

    // exception beats stall and redirect; held req is masked in EXC
    req = 1'b1; stall = 1'b1; d_redirect = 1'b1; d_target = 32'h0000_3200;
    do_cycle();
    chk("exc_pc", 0, pc_o[0], 32'h0000_4180);
    chk("exc_state", 0, {30'b0, state_o[0]}, 32'd1);
    stall = 1'b0; d_redirect = 1'b0;
    do_cycle();
    req = 1'b0;
    chk("exc_once_pc", 0, pc_o[0], 32'h0000_4184);
    chk("exc_once_state", 0, {30'b0, state_o[0]}, 32'd0);

    // eret from 4200 to epc 3010
    d_redirect = 1'b1; d_target = 32'h0000_4200;
    do_cycle();
    d_redirect = 1'b0;
    eret_d = 1'b1; epc = 32'h0000_3010;
    #1;
    chk("eret_kill", 0, {31'b0, kill_o[0]}, 32'd1);
    do_cycle();
    eret_d = 1'b0;
    chk("eret_pc", 0, pc_o[0], 32'h0000_3010);
    chk("eret_state", 0, {30'b0, state_o[0]}, 32'd2);
    do_cycle();
    chk("eret_run", 0, {30'b0, state_o[0]}, 32'd0);

    // misaligned target, then continuing past it with a wide limit
    d_redirect = 1'b1; d_target = 32'h0000_3002;
    do_cycle();
    d_redirect = 1'b0;
    chk("mis_adel", 0, {31'b0, adel_o[0]}, 32'd1);
    chk("mis_code", 0, {27'b0, code_o[0]}, 32'd4);
    chk("mis_valid", 0, {31'b0, valid_o[0]}, 32'd0);
    do_cycle();
    chk("mis_next", 1, pc_o[1], 32'h0000_3006);

    // above the default limit
    d_redirect = 1'b1; d_target = 32'h0000_7000;
    do_cycle();
    chk("hi_adel", 0, {31'b0, adel_o[0]}, 32'd1);
    chk("hi_wide_ok", 1, {31'b0, adel_o[1]}, 32'd0);

    // wrap from ffff_fffc to zero
    d_target = 32'hffff_fffc;
    do_cycle();
    d_redirect = 1'b0;
    do_cycle();
    chk("wrap_pc", 2, pc_o[2], 32'h0000_0000);
    chk("wrap_adel", 2, {31'b0, adel_o[2]}, 32'd0);
    chk("wrap_base", 1, {31'b0, adel_o[1]}, 32'd1);

    // reset in the middle of EXC and of a stall
    req = 1'b1;
    do_cycle();
    req = 1'b0;
    apply_reset();
    stall = 1'b1;
    do_cycle();
    stall = 1'b0;
    apply_reset();
    do_cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      req        = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      eret_d     = ($urandom_range(0, 11) == 0);
      d_redirect = ($urandom_range(0, 3) == 0);
      f_is_ctrl  = ($urandom_range(0, 4) == 0);
      epc        = 32'h0000_3000 + ($urandom_range(0, 16'h0fff) << 2);
      case ($urandom_range(0, 5))
        0:       d_target = 32'h0000_3000 + ($urandom_range(0, 32'h0fff) << 2) + $urandom_range(1, 3);
        1:       d_target = $urandom;
        2:       d_target = 32'hffff_fff8;
        3:       d_target = 32'h0000_6ffc;
        default: d_target = 32'h0000_3000 + ($urandom_range(0, 32'h0fff) << 2);
      endcase
      if ($urandom_range(0, 79) == 0) begin
        apply_reset();
      end
      do_cycle();
    end

    idle_inputs();
    do_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the F-stage program counter of the five-stage MIPS pipeline. Each cycle it picks the next fetch address from exception entry, `eret` return, hazard stall, D-stage control-transfer redirect or sequential increment. It registers the result and tags the fetched word with delay-slot and fetch-exception status for the F/D pipeline register. It sits between the hazard unit, the D-stage branch/jump resolver, CP0 and the instruction memory.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch address after reset
- `EXC_PC`, 32'h0000_4180, exception/interrupt handler entry
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address
- `IM_LIMIT`, 32'h0000_6ffc, highest legal fetch address
- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: asynchronous, active-high
- `stall` input 1: hazard unit freezes the F stage
- `req` input 1: CP0 exception/interrupt request (taken at M)
- `d_redirect` input 1: D-stage branch taken, `j`/`jal` or `jr`/`jalr` resolved
- `d_target` input 32: redirect address, valid with `d_redirect`
- `eret_d` input 1: `eret` in D
- `epc` input 32: CP0 EPC
- `f_is_ctrl` input 1: pre-decode says the word at `f_pc` is a branch/jump
- `f_pc` output 32: current fetch address
- `f_bd` output 1: word at `f_pc` is a delay-slot instruction
- `f_valid` output 1: 0 means F/D must load a nop
- `f_kill` output 1: squash the word currently in F (combinational)
- `f_adel` output 1: fetch address error
- `f_exc_code` output 5: 5'd4 when `f_adel`, else 0
- `state` output 2: FSM state, for debug

## Operation
- FSM states: RUN=2'd0, EXC=2'd1, ERET=2'd2.
- Next-PC priority, evaluated every cycle:
  - `req` in RUN or ERET: load `EXC_PC`, clear `f_bd`, go to EXC. This ignores `stall`.
  - `eret_d & !stall`: load `epc`, clear `f_bd`, go to ERET, and assert `f_kill` this cycle. `eret` has no delay slot.
  - `stall`: hold `f_pc`, `f_bd` and state.
  - `d_redirect`: load `d_target`, set `f_bd` to 0.
  - Otherwise: load `f_pc + 4` (mod 2^32, wraps silently) and set `f_bd` to `f_is_ctrl`.
- The delay slot is always fetched. `d_redirect` is asserted while the delay slot sits in F, so that word keeps its `f_bd` and is not killed.
- EXC lasts exactly one cycle. `req` is masked in EXC because CP0 may hold Req while M drains. The next state is RUN; stall/redirect/sequential rules still apply to the PC.
- ERET lasts one cycle, then RUN. `req` in ERET is honoured.
- Address check (combinational on `f_pc`):
  - `f_adel` = (`f_pc[1:0]` != 0) | (`f_pc` < `IM_BASE`) | (`f_pc` > `IM_LIMIT`).
  - When `f_adel`: `f_valid`=0 and `f_exc_code`=4. The exception is still carried down the pipe, and the sequencer keeps incrementing until `req` arrives.
- `f_valid` = !`f_adel`.
- `f_kill` = `eret_d & !stall & !(req & state!=EXC)`.

## Timing
- Reset (async, immediate) sets: `f_pc`=`RESET_PC`, `f_bd`=0, `state`=RUN, `f_valid`=1, `f_kill`=0, `f_adel`=0, `f_exc_code`=0.
- Deasserting reset: the first rising edge advances to `RESET_PC+4` unless stalled.
- Redirect latency is one edge. A source sampled in cycle n appears on `f_pc` in cycle n+1.
- `f_kill`, `f_adel`, `f_exc_code` and `f_valid` are same-cycle combinational. They carry no registered delay.
- Simultaneous events are resolved by the priority list:
  - `req` beats `eret_d`, `stall` and `d_redirect`.
  - `eret_d` with `stall` does nothing until `stall` drops.
- Reset mid-EXC or mid-stall returns to the reset values immediately.

## Test plan
- Reset then 3 free edges: `f_pc` goes 3000→3004→3008→300c, `f_bd`=0.
- `stall`=1 for 2 cycles at `f_pc`=3008: `f_pc` holds 3008 on both edges, then 300c.
- Branch at 3004 (`f_is_ctrl`=1 at 3004), `d_redirect`=1 with `d_target`=3100 while F=3008: `f_bd`=1 at 3008, next `f_pc`=3100 with `f_bd`=0.
- `req`=1 with `stall`=1 and `d_redirect`=1, `req` held 2 cycles:
  - `f_pc`=4180 and state EXC for one cycle.
  - Next cycle state RUN, `f_pc`=4184 (no re-entry).
- `eret_d`=1, `epc`=3010 at `f_pc`=4200: `f_kill`=1 that cycle, next `f_pc`=3010, state ERET then RUN.
- `d_target`=3002: `f_adel`=1, `f_exc_code`=4, `f_valid`=0. `d_target`=7000 gives the same response.
- Repeat the `d_target`=3002 case with `IM_LIMIT`=32'hffff_fffc: next `f_pc` after 3002 is 3006.
- Repeat with `IM_LIMIT`=32'hffff_fffc and `IM_BASE`=0 from `f_pc`=ffff_fffc: it wraps to 0000_0000.
